// File: rtl/imm_pkg.sv
// Shared types and opcode constants for the immediate generator.
//   fmt_e     : format code presented alongside each decoded immediate
//   OPC_*     : RV32I major opcodes (instr[6:0]) that carry or imply an immediate
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd6
    } fmt_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

endpackage

// File: rtl/imm_decode.sv
// Combinational RV32I immediate decoder.
//   i_instr   : 32-bit instruction word
//   o_imm     : immediate sign-extended to XLEN (0 for R-type and illegal)
//   o_fmt     : format code
//   o_illegal : opcode not recognised (covers instr[1:0] != 2'b11, since
//               every listed opcode ends in 2'b11)
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    output logic [XLEN-1:0] o_imm,
    output fmt_e            o_fmt,
    output logic            o_illegal
);

    // Every format fits a 32-bit value whose bit 31 is already the sign,
    // so the XLEN result is a plain signed widening of this.
    logic [31:0] w_raw;

    always_comb begin
        w_raw     = '0;
        o_fmt     = FMT_ILL;
        o_illegal = 1'b1;
        case (i_instr[6:0])
            OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM: begin
                w_raw     = {{20{i_instr[31]}}, i_instr[31:20]};
                o_fmt     = FMT_I;
                o_illegal = 1'b0;
            end
            OPC_STORE: begin
                w_raw     = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
                o_fmt     = FMT_S;
                o_illegal = 1'b0;
            end
            OPC_BRANCH: begin
                w_raw     = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                             i_instr[30:25], i_instr[11:8], 1'b0};
                o_fmt     = FMT_B;
                o_illegal = 1'b0;
            end
            OPC_LUI, OPC_AUIPC: begin
                w_raw     = {i_instr[31:12], 12'b0};
                o_fmt     = FMT_U;
                o_illegal = 1'b0;
            end
            OPC_JAL: begin
                w_raw     = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                             i_instr[20], i_instr[30:21], 1'b0};
                o_fmt     = FMT_J;
                o_illegal = 1'b0;
            end
            OPC_OP: begin
                o_fmt     = FMT_R;
                o_illegal = 1'b0;
            end
            default: ;
        endcase
    end

    assign o_imm = XLEN'(signed'(w_raw));

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with valid/ready handshake and 2-entry
// skid buffer (main = presented entry, skid = overflow while stalled).
//   clk, rst_n            : clock, async active-low reset
//   flush                 : drop both held entries at the next edge
//   in_valid/in_ready     : upstream handshake; in_instr, in_tag payload
//   out_valid/out_ready   : downstream handshake
//   out_imm/fmt/illegal   : decoded fields of the presented instruction
//   out_tag               : tag carried with the presented instruction
//   illegal_cnt           : saturating count of illegal entries sent downstream
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output fmt_e             out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] illegal_cnt
);

    logic [XLEN-1:0]  w_dec_imm;
    fmt_e             w_dec_fmt;
    logic             w_dec_ill;

    imm_decode #(.XLEN(XLEN)) u_dec (
        .i_instr   (in_instr),
        .o_imm     (w_dec_imm),
        .o_fmt     (w_dec_fmt),
        .o_illegal (w_dec_ill)
    );

    logic             r_m_vld, r_s_vld;
    logic [XLEN-1:0]  r_m_imm, r_s_imm;
    fmt_e             r_m_fmt, r_s_fmt;
    logic             r_m_ill, r_s_ill;
    logic [TAG_W-1:0] r_m_tag, r_s_tag;
    logic [CNT_W-1:0] r_cnt;

    logic w_in_fire, w_out_fire, w_m_free;

    // in_ready comes straight from the skid valid flop.
    assign in_ready   = !r_s_vld;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_m_vld && out_ready;
    assign w_m_free   = !r_m_vld || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_vld <= 1'b0;
            r_m_imm <= '0;
            r_m_fmt <= FMT_R;
            r_m_ill <= 1'b0;
            r_m_tag <= '0;
            r_s_vld <= 1'b0;
            r_s_imm <= '0;
            r_s_fmt <= FMT_R;
            r_s_ill <= 1'b0;
            r_s_tag <= '0;
        end else if (flush) begin
            r_m_vld <= 1'b0;
            r_s_vld <= 1'b0;
        end else if (w_m_free) begin
            // Skid is only ever full behind a valid main entry, and
            // in_ready is low then, so no input can be lost here.
            if (r_s_vld) begin
                r_m_vld <= 1'b1;
                r_m_imm <= r_s_imm;
                r_m_fmt <= r_s_fmt;
                r_m_ill <= r_s_ill;
                r_m_tag <= r_s_tag;
                r_s_vld <= 1'b0;
            end else if (w_in_fire) begin
                r_m_vld <= 1'b1;
                r_m_imm <= w_dec_imm;
                r_m_fmt <= w_dec_fmt;
                r_m_ill <= w_dec_ill;
                r_m_tag <= in_tag;
            end else begin
                r_m_vld <= 1'b0;
            end
        end else if (w_in_fire) begin
            r_s_vld <= 1'b1;
            r_s_imm <= w_dec_imm;
            r_s_fmt <= w_dec_fmt;
            r_s_ill <= w_dec_ill;
            r_s_tag <= in_tag;
        end
    end

    // Counts independently of flush: a transfer on the flush edge still happened.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (w_out_fire && r_m_ill && (r_cnt != {CNT_W{1'b1}}))
            r_cnt <= r_cnt + 1'b1;
    end

    assign out_valid   = r_m_vld;
    assign out_imm     = r_m_imm;
    assign out_fmt     = r_m_fmt;
    assign out_illegal = r_m_ill;
    assign out_tag     = r_m_tag;
    assign illegal_cnt = r_cnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;
    import imm_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic [31:0] in_tag = '0;
    logic        out_ready = 1'b0;

    // 32-bit / wide-counter instance and 64-bit / 2-bit-counter instance
    // driven by the same stimulus.
    logic        a_in_ready, a_out_valid, a_ill;
    logic [31:0] a_imm, a_tag;
    fmt_e        a_fmt;
    logic [15:0] a_cnt;
    logic        b_in_ready, b_out_valid, b_ill;
    logic [63:0] b_imm;
    logic [31:0] b_tag;
    fmt_e        b_fmt;
    logic [1:0]  b_cnt;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32), .CNT_W(16)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_imm(a_imm), .out_fmt(a_fmt),
        .out_illegal(a_ill), .out_tag(a_tag), .illegal_cnt(a_cnt)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32), .CNT_W(2)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_imm(b_imm), .out_fmt(b_fmt),
        .out_illegal(b_ill), .out_tag(b_tag), .illegal_cnt(b_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    vec_t vecs[15];
    int   n_ill;
    int   base_a;

    initial begin
        vecs[0]  = '{32'hFE000EE3, 32'hFFFFFFFC, FMT_B,   1'b0}; // beq -4
        vecs[1]  = '{32'hFFF12083, 32'hFFFFFFFF, FMT_I,   1'b0}; // lw -1
        vecs[2]  = '{32'hFE112E23, 32'hFFFFFFFC, FMT_S,   1'b0}; // sw -4
        vecs[3]  = '{32'h0080006F, 32'h00000008, FMT_J,   1'b0}; // jal +8
        vecs[4]  = '{32'h123450B7, 32'h12345000, FMT_U,   1'b0}; // lui
        vecs[5]  = '{32'h800000B7, 32'h80000000, FMT_U,   1'b0}; // lui, sign bit set
        vecs[6]  = '{32'h0000007F, 32'h00000000, FMT_ILL, 1'b1};
        vecs[7]  = '{32'h00000000, 32'h00000000, FMT_ILL, 1'b1};
        vecs[8]  = '{32'h00B50533, 32'h00000000, FMT_R,   1'b0}; // add
        vecs[9]  = '{32'h00500093, 32'h00000005, FMT_I,   1'b0}; // addi 5
        vecs[10] = '{32'hFFFFF117, 32'hFFFFF000, FMT_U,   1'b0}; // auipc
        vecs[11] = '{32'h7FF08067, 32'h000007FF, FMT_I,   1'b0}; // jalr +2047
        vecs[12] = '{32'h00000073, 32'h00000000, FMT_I,   1'b0}; // ecall
        vecs[13] = '{32'hFFF12082, 32'h00000000, FMT_ILL, 1'b1}; // low bits 2'b10
        vecs[14] = '{32'h00209463, 32'h00000008, FMT_B,   1'b0}; // bne +8

        // Reset state
        #12;
        chk("rst out_valid", 64'(a_out_valid), 64'd0);
        chk("rst in_ready",  64'(a_in_ready),  64'd1);
        chk("rst imm",       64'(a_imm),       64'd0);
        chk("rst fmt",       64'(a_fmt),       64'(FMT_R));
        chk("rst cnt",       64'(a_cnt),       64'd0);
        rst_n = 1'b1;
        tick();

        // Table: back-to-back, one result per cycle, latency 1
        out_ready = 1'b1;
        n_ill = 0;
        for (int i = 0; i < 15; i++) begin
            in_valid = 1'b1;
            in_instr = vecs[i].instr;
            in_tag   = 32'hA000 + i;
            tick();
            chk($sformatf("v%0d valid", i), 64'(a_out_valid), 64'd1);
            chk($sformatf("v%0d imm", i),   64'(a_imm),       64'(vecs[i].imm));
            chk($sformatf("v%0d imm64", i), b_imm,            {{32{vecs[i].imm[31]}}, vecs[i].imm});
            chk($sformatf("v%0d fmt", i),   64'(a_fmt),       64'(vecs[i].fmt));
            chk($sformatf("v%0d ill", i),   64'(a_ill),       64'(vecs[i].ill));
            chk($sformatf("v%0d tag", i),   64'(a_tag),       64'(32'hA000 + i));
            if (vecs[i].ill) n_ill++;
        end
        in_valid = 1'b0;
        tick();
        chk("drain out_valid", 64'(a_out_valid), 64'd0);
        chk("cnt after table", 64'(a_cnt), 64'(n_ill));
        chk("cnt2 after table", 64'(b_cnt), 64'd3);

        // Two more illegals: wide counter keeps counting, 2-bit one holds at 3
        base_a = int'(a_cnt);
        in_valid = 1'b1; in_instr = 32'h0000007F; tick();
        in_instr = 32'h00000000; tick();
        in_valid = 1'b0; tick();
        chk("cnt +2", 64'(a_cnt), 64'(base_a + 2));
        chk("cnt2 saturated", 64'(b_cnt), 64'd3);

        // Stall: 2 accepted, third refused, both released in order
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'hFFF12083; in_tag = 32'hB1; tick();
        chk("stall in_ready 1", 64'(a_in_ready), 64'd1);
        chk("stall tag A",      64'(a_tag),      64'hB1);
        in_instr = 32'h0080006F; in_tag = 32'hB2; tick();
        chk("stall in_ready 0", 64'(a_in_ready), 64'd0);
        chk("stall hold tag",   64'(a_tag),      64'hB1);
        chk("stall hold imm",   64'(a_imm),      64'hFFFFFFFF);
        in_instr = 32'h00500093; in_tag = 32'hB3; tick();
        chk("stall still full", 64'(a_in_ready), 64'd0);
        chk("stall hold tag2",  64'(a_tag),      64'hB1);
        in_valid = 1'b0; out_ready = 1'b1; tick();
        chk("release tag B",    64'(a_tag),      64'hB2);
        chk("release imm B",    64'(a_imm),      64'h8);
        chk("release in_ready", 64'(a_in_ready), 64'd1);
        tick();
        chk("release empty",    64'(a_out_valid), 64'd0);

        // Flush with both entries full, input valid and an output transfer
        base_a = int'(a_cnt);
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h0000007F; in_tag = 32'hC1; tick();
        in_tag = 32'hC2; tick();
        chk("pre-flush full", 64'(a_in_ready), 64'd0);
        in_instr = 32'h00500093; in_tag = 32'hC3; flush = 1'b1; out_ready = 1'b1; tick();
        chk("flush out_valid", 64'(a_out_valid), 64'd0);
        chk("flush in_ready",  64'(a_in_ready),  64'd1);
        chk("flush cnt",       64'(a_cnt),       64'(base_a + 1));
        flush = 1'b0; in_valid = 1'b0; tick();
        chk("flush dropped",   64'(a_out_valid), 64'd0);

        // 64-bit U-type explicit values
        in_valid = 1'b1; in_instr = 32'h123450B7; tick();
        chk("lui64 pos", b_imm, 64'h00000000_12345000);
        in_instr = 32'h800000B7; tick();
        chk("lui64 neg", b_imm, 64'hFFFFFFFF_80000000);
        in_valid = 1'b0; tick();

        // Async reset mid-stall
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'hFFF12083; in_tag = 32'hD1; tick();
        in_tag = 32'hD2; tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst out_valid", 64'(a_out_valid), 64'd0);
        chk("arst in_ready",  64'(a_in_ready),  64'd1);
        chk("arst imm",       64'(a_imm),       64'd0);
        chk("arst fmt",       64'(a_fmt),       64'(FMT_R));
        chk("arst tag",       64'(a_tag),       64'd0);
        chk("arst cnt",       64'(a_cnt),       64'd0);
        chk("arst cnt2",      64'(b_cnt),       64'd0);
        rst_n = 1'b1;
        tick();
        chk("arst entries lost", 64'(a_out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
